// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states and bit-timing helpers.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Receiver and transmitter must derive bit timing identically, so both use this.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data and an occupancy count.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = width_of(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  // NOTE: storage is deliberately not reset; the flushed count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte stream into a FIFO, serialised LSB first with gap-free frames.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int N_BITS     = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] uart_tx_tdata,
  input  logic              uart_tx_tvalid,
  output logic              uart_tx_tready,
  output logic              tx_data,
  output logic              tx_busy,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BAUD_W = width_of(CPB);
  localparam int BIT_W  = width_of(N_BITS);

  tx_state_e          state_q;
  logic [BAUD_W-1:0]  baud_q;
  logic [BIT_W-1:0]   bit_q;
  logic [N_BITS-1:0]  shift_q;
  logic               tx_data_q;
  logic               tx_busy_q;
  logic               tready_q;

  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [N_BITS-1:0]  fifo_rd_data;
  logic [CNT_W-1:0]   count_d;
  logic               baud_last;
  logic               bit_last;
  logic               line_d;

  sync_fifo #(
    .WIDTH (N_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (uart_tx_tdata),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign push      = uart_tx_tvalid & tready_q & ~fifo_full;
  assign baud_last = (baud_q == BAUD_W'(CPB - 1));
  assign bit_last  = (bit_q == BIT_W'(N_BITS - 1));
  // Popping on the last stop-bit cycle chains the next frame with no idle gap.
  assign pop       = ~fifo_empty & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_last));
  assign count_d   = fifo_count + CNT_W'(push) - CNT_W'(pop);

  // NOTE: default assignment first so no path leaves line_d unassigned (no latch).
  always_comb begin
    line_d = 1'b1;
    case (state_q)
      ST_START: line_d = 1'b0;
      ST_DATA:  line_d = shift_q[0];
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_data_q <= 1'b1;
      tx_busy_q <= 1'b0;
      tready_q  <= 1'b0;
    end else begin
      tx_data_q <= line_d;
      tx_busy_q <= (state_q != ST_IDLE);
      tready_q  <= (count_d != CNT_W'(FIFO_DEPTH));
      case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          if (pop) begin
            shift_q <= fifo_rd_data;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_last) state_q <= ST_STOP;
            else          bit_q   <= bit_q + BIT_W'(1);
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= fifo_rd_data;
              state_q <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_busy        = tx_busy_q;
  assign uart_tx_tready = tready_q;

endmodule
